bitwise_logic_unit: RTL and testbench
=====================================

# bitwise_logic_unit

Parametrised, multi-cycle bitwise logic unit for the ALU/multdiv datapath. It generalises the fixed 32-bit AND to any width and eight selectable logic operations. It processes SLICE bits per cycle behind a valid/ready handshake, and it reports zero and all-ones flags on the completed result. Its intended use is area-constrained datapaths where a full-width single-cycle logic array is not wanted.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8: bits computed per cycle; N = WIDTH/SLICE slice cycles per operation (N ≥ 1).
- clock  input  1  single clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- data_operandA  input  WIDTH  operand A.
- data_operandB  input  WIDTH  operand B.
- ctrl_op  input  3  operation: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (A & ~B), 111 PASSA (A).
- flush  input  1  synchronous abort of the operation in flight.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts the result.
- data_result  output  WIDTH  registered result.
- isZero  output  1  data_result == 0; valid while out_valid.
- allOnes  output  1  data_result == all ones; valid while out_valid.

## Operation
- States: IDLE, BUSY, DONE. Encoding is free.
- IDLE: in_ready=1. On in_valid && in_ready, capture A, B, and ctrl_op into internal registers, clear the slice counter to 0, and go to BUSY. Later input changes do not affect the operation.
- BUSY: each cycle, compute slice k (bits k·SLICE+SLICE-1 : k·SLICE) from the captured operands. Slice 0 (LSBs) goes first. Write the slice into the result register and increment k. When k = N-1 is written, go to DONE.
- Running zero/ones accumulators update with each slice: zero &= (slice==0) and ones &= (slice all 1). Both are initialised to 1 on accept. They are presented as isZero/allOnes in DONE.
- DONE: out_valid=1. data_result, isZero, and allOnes are stable. On out_ready, go to IDLE. Nothing is accepted in DONE (in_ready=0).
- flush: if flush=1 in BUSY or DONE, go to IDLE next edge with out_valid=0. data_result keeps its partially written contents. flush in IDLE has no effect. flush takes priority over out_ready and slice completion.
- Result bits not yet written in BUSY hold their previous values. Consumers must use data_result only while out_valid=1.
- The operation is purely bitwise: no carries, no sign handling, no width extension.

## Timing
- Reset values (asynchronous on reset_n low): state IDLE, in_ready=1 after reset release, out_valid=0, data_result=0, isZero=0, allOnes=0, slice counter 0.
- Reset mid-operation aborts immediately. There is no pending output after release.
- Latency: accept on edge t. Slices are written on edges t+1 … t+N. out_valid is high from edge t+N, i.e. N cycles after the accept edge.
- Throughput: with out_ready held high, one operation per N+2 cycles (accept, N BUSY, one DONE cycle, IDLE).
- in_ready is a registered state decode. It is combinationally independent of in_valid and out_ready.
- out_valid does not drop without out_ready, flush, or reset.
- N=1 (SLICE=WIDTH): BUSY lasts one cycle, and out_valid rises one cycle after accept.

## Test plan
- WIDTH=32, SLICE=8, AND, A=0xF0F0_1234, B=0x0FF0_FFFF -> data_result=0x00F0_1234, isZero=0, allOnes=0, out_valid rises exactly 4 cycles after accept.
- XOR, A=B=0xDEAD_BEEF -> 0x0000_0000, isZero=1. Then XNOR on the same operands -> 0xFFFF_FFFF, allOnes=1. Cover all 8 ctrl_op codes against a reference model using random operands.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and data_result stay stable and in_ready=0 throughout. Raising out_ready returns the unit to IDLE the next cycle.
- Change data_operandA, data_operandB, and ctrl_op every cycle during BUSY -> the result reflects only the values captured at accept.
- flush on BUSY cycle 2 -> IDLE next cycle, out_valid never rises, and in_ready=1. Pull reset_n low in BUSY -> all outputs go to reset values immediately, with no out_valid after release.
- SLICE=32 (N=1) and WIDTH=16/SLICE=4: OR 0x00FF|0x0F00 -> 0x0FFF. Latencies are 1 and 4 cycles respectively.

Source files
------------

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: applies one of eight logic operations SLICE bits per cycle
// behind a valid/ready handshake and reports zero / all-ones flags on the finished result.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [2:0]       ctrl_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isZero,
    output logic             allOnes
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [SLICE-1:0] logic_op(input logic [2:0] op,
                                                  input logic [SLICE-1:0] a,
                                                  input logic [SLICE-1:0] b);
        logic [SLICE-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = a & ~b;
            3'd7:    r = a;
            default: r = a;
        endcase
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic             zero_q, zero_d, ones_q, ones_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [SLICE-1:0] slice_s;
    logic             last_s;
    int unsigned      base_s;

    assign base_s  = 32'(k_q) * 32'(SLICE);
    assign last_s  = (k_q == KW'(N - 1));
    assign slice_s = logic_op(op_q, a_q[base_s +: SLICE], b_q[base_s +: SLICE]);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush outranks both slice completion and out_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_BUSY;
                else          state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (flush)       state_d = ST_IDLE;
                else if (last_s) state_d = ST_DONE;
                else             state_d = ST_BUSY;
            end
            ST_DONE: begin
                if (flush || out_ready) state_d = ST_IDLE;
                else                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; unwritten result slices hold their old bits
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        k_d    = k_q;
        res_d  = res_q;
        zero_d = zero_q;
        ones_d = ones_q;
        if (state_q == ST_IDLE && in_valid) begin
            a_d    = data_operandA;
            b_d    = data_operandB;
            op_d   = ctrl_op;
            k_d    = '0;
            zero_d = 1'b1;
            ones_d = 1'b1;
        end else if (state_q == ST_BUSY && !flush) begin
            res_d[base_s +: SLICE] = slice_s;
            zero_d = zero_q & (slice_s == '0);
            ones_d = ones_q & (slice_s == '1);
            k_d    = last_s ? '0 : k_q + KW'(1);
        end else begin
            k_d = k_q;
        end
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // Datapath and handshake registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 3'd0;
            k_q         <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            k_q         <= k_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign data_result = res_q;
    assign isZero      = zero_q;
    assign allOnes     = ones_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Randomised self-checking bench for bitwise_logic_unit against a full-width reference model,
// plus directed latency checks for the N=1 and WIDTH=16/SLICE=4 configurations.
module tb_bitwise_logic_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv0, ir0, fl0, ov0, or0, z0, o0;
    logic [31:0] a0, b0, res0;
    logic [2:0]  op0;
    logic        iv1, ir1, fl1, ov1, or1, z1, o1;
    logic [31:0] a1, b1, res1;
    logic [2:0]  op1;
    logic        iv2, ir2, fl2, ov2, or2, z2, o2;
    logic [15:0] a2, b2, res2;
    logic [2:0]  op2;

    int checks = 0;
    int errors = 0;

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) u0 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .data_operandA(a0), .data_operandB(b0), .ctrl_op(op0), .flush(fl0),
        .out_valid(ov0), .out_ready(or0), .data_result(res0), .isZero(z0), .allOnes(o0));

    bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) u1 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .data_operandA(a1), .data_operandB(b1), .ctrl_op(op1), .flush(fl1),
        .out_valid(ov1), .out_ready(or1), .data_result(res1), .isZero(z1), .allOnes(o1));

    bitwise_logic_unit #(.WIDTH(16), .SLICE(4)) u2 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .data_operandA(a2), .data_operandB(b2), .ctrl_op(op2), .flush(fl2),
        .out_valid(ov2), .out_ready(or2), .data_result(res2), .isZero(z2), .allOnes(o2));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    // One full operation on u0: accept, wait for out_valid, check, optionally stall, consume
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input int hold);
        logic [31:0] exp;
        int lat;
        exp = ref_op(op, a, b);
        @(negedge clk);
        check_eq("in_ready_idle", 64'(ir0), 64'd1);
        iv0 = 1'b1; op0 = op; a0 = a; b0 = b;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 20) begin
            if (scramble) begin
                a0 = $urandom; b0 = $urandom; op0 = 3'($urandom);
            end
            check_eq("in_ready_busy", 64'(ir0), 64'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 64'(lat), 64'd4);
        check_eq("out_valid", 64'(ov0), 64'd1);
        check_eq("result", 64'(res0), 64'(exp));
        check_eq("isZero", 64'(z0), 64'(exp == 32'd0));
        check_eq("allOnes", 64'(o0), 64'(exp == 32'hFFFF_FFFF));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_valid", 64'(ov0), 64'd1);
            check_eq("stall_result", 64'(res0), 64'(exp));
            check_eq("stall_in_ready", 64'(ir0), 64'd0);
        end
        or0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or0 = 1'b0;
        check_eq("consumed_valid", 64'(ov0), 64'd0);
        check_eq("consumed_in_ready", 64'(ir0), 64'd1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        {iv0, fl0, or0, iv1, fl1, or1, iv2, fl2, or2} = 9'd0;
        a0 = 32'd0; b0 = 32'd0; op0 = 3'd0;
        a1 = 32'd0; b1 = 32'd0; op1 = 3'd0;
        a2 = 16'd0; b2 = 16'd0; op2 = 3'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 64'(ov0), 64'd0);
        check_eq("rst_result", 64'(res0), 64'd0);
        check_eq("rst_isZero", 64'(z0), 64'd0);
        check_eq("rst_allOnes", 64'(o0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", 64'(ir0), 64'd1);
        check_eq("rel_out_valid", 64'(ov0), 64'd0);

        run_op(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 0);
        run_op(3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
        run_op(3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
        run_op(3'd6, $urandom, $urandom, 1'b0, 3);
        run_op(3'd1, $urandom, $urandom, 1'b1, 0);
        run_op(3'd3, $urandom, $urandom, 1'b1, 1);
        for (int i = 0; i < 32; i++) begin
            run_op(3'(i % 8), $urandom, $urandom, 1'($urandom), $urandom_range(0, 2));
        end

        // Flush on the second BUSY cycle
        @(negedge clk);
        iv0 = 1'b1; op0 = 3'd1; a0 = $urandom; b0 = $urandom;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        fl0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fl0 = 1'b0;
        check_eq("flush_in_ready", 64'(ir0), 64'd1);
        check_eq("flush_valid", 64'(ov0), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("flush_no_valid", 64'(ov0), 64'd0);
        end
        run_op(3'd4, $urandom, $urandom, 1'b0, 0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        iv0 = 1'b1; op0 = 3'd7; a0 = 32'hFFFF_FFFF; b0 = $urandom;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(ov0), 64'd0);
        check_eq("arst_result", 64'(res0), 64'd0);
        check_eq("arst_isZero", 64'(z0), 64'd0);
        check_eq("arst_allOnes", 64'(o0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("arst_no_valid", 64'(ov0), 64'd0);
        end
        check_eq("arst_in_ready", 64'(ir0), 64'd1);
        run_op(3'd0, $urandom, $urandom, 1'b0, 0);

        // N=1 configuration
        @(negedge clk);
        check_eq("n1_in_ready", 64'(ir1), 64'd1);
        iv1 = 1'b1; op1 = 3'd1; a1 = 32'h0000_00FF; b1 = 32'h0000_0F00;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("n1_latency", 64'(lat), 64'd1);
        check_eq("n1_result", 64'(res1), 64'h0000_0FFF);
        check_eq("n1_isZero", 64'(z1), 64'd0);
        or1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or1 = 1'b0;
        check_eq("n1_consumed", 64'(ov1), 64'd0);

        // WIDTH=16, SLICE=4 configuration
        @(negedge clk);
        check_eq("w16_in_ready", 64'(ir2), 64'd1);
        iv2 = 1'b1; op2 = 3'd1; a2 = 16'h00FF; b2 = 16'h0F00;
        @(posedge clk);
        @(negedge clk);
        iv2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("w16_latency", 64'(lat), 64'd4);
        check_eq("w16_result", 64'(res2), 64'h0FFF);
        check_eq("w16_allOnes", 64'(o2), 64'd0);
        or2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or2 = 1'b0;
        check_eq("w16_consumed", 64'(ov2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
